// File: rtl/master_port.sv
// Serial bus master: converts one parallel device request into an LSB-first
// serial address/data transaction and assembles the serial read response.
module master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dvalid,
    output logic                  dready,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  ddone,
    output logic                  derr,
    output logic                  mwdata,
    output logic                  mmode,
    output logic                  mvalid,
    input  logic                  mrdata,
    input  logic                  svalid,
    input  logic                  sready
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WAIT, ADDR, WDATA, RWAIT, RDATA, DONE} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         wait_q, wait_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
    logic                  mvalid_q, mvalid_d;
    logic                  mwdata_q, mwdata_d;
    logic                  mmode_q, mmode_d;
    logic                  ddone_q, ddone_d;
    logic                  derr_q, derr_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wait_q   <= '0;
            mode_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rd_q     <= '0;
            full_q   <= 1'b0;
            drdata_q <= '0;
            mvalid_q <= 1'b0;
            mwdata_q <= 1'b0;
            mmode_q  <= 1'b0;
            ddone_q  <= 1'b0;
            derr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rd_q     <= rd_d;
            full_q   <= full_d;
            drdata_q <= drdata_d;
            mvalid_q <= mvalid_d;
            mwdata_q <= mwdata_d;
            mmode_q  <= mmode_d;
            ddone_q  <= ddone_d;
            derr_q   <= derr_d;
        end
    end

    // Address and write data leave via right shifts, so bit 0 is always next out.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rd_d     = rd_q;
        full_d   = full_q;
        drdata_d = drdata_q;
        mvalid_d = mvalid_q;
        mwdata_d = mwdata_q;
        mmode_d  = mmode_q;
        ddone_d  = 1'b0;
        derr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (dvalid) begin
                    mode_d  = dmode;
                    addr_d  = daddr;
                    data_d  = dwdata;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (sready) begin
                    mvalid_d = 1'b1;
                    mwdata_d = addr_q[0];
                    addr_d   = addr_q >> 1;
                    mmode_d  = mode_q;
                    cnt_d    = '0;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (cnt_q == ADDR_LAST) begin
                    cnt_d = '0;
                    if (mode_q) begin
                        mwdata_d = data_q[0];
                        data_d   = data_q >> 1;
                        state_d  = WDATA;
                    end else begin
                        mvalid_d = 1'b0;
                        mwdata_d = 1'b0;
                        wait_d   = '0;
                        full_d   = 1'b0;
                        rd_d     = '0;
                        state_d  = RWAIT;
                    end
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    mwdata_d = addr_q[0];
                    addr_d   = addr_q >> 1;
                end
            end
            WDATA: begin
                if (cnt_q == DATA_LAST) begin
                    mvalid_d = 1'b0;
                    mwdata_d = 1'b0;
                    ddone_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    mwdata_d = data_q[0];
                    data_d   = data_q >> 1;
                end
            end
            // Read bits enter at the MSB so the first bit ends at bit 0 once full;
            // the completed word is published one cycle after the last capture.
            RWAIT, RDATA: begin
                if (full_q) begin
                    drdata_d = rd_q;
                    ddone_d  = 1'b1;
                    state_d  = DONE;
                end else if (svalid) begin
                    rd_d    = {mrdata, rd_q[DATA_WIDTH-1:1]};
                    wait_d  = '0;
                    state_d = RDATA;
                    if (cnt_q == DATA_LAST) begin
                        full_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (wait_q == WAIT_LAST) begin
                    ddone_d = 1'b1;
                    derr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            DONE: begin
                mmode_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dready = (state_q == IDLE);
    assign drdata = drdata_q;
    assign ddone  = ddone_q;
    assign derr   = derr_q;
    assign mwdata = mwdata_q;
    assign mmode  = mmode_q;
    assign mvalid = mvalid_q;

endmodule

// File: doc/master_port.md
# master_port

Bus master interface that turns one parallel request from a local device into the serial bus transaction the slave accepts, and turns the slave's serial read response back into a parallel word. It sits directly upstream of the slave. It drives address and write data serially, LSB first, one bit per clock, and captures returned read data the same way. It handles one transaction at a time and has a read-response timeout.

## Interface
- ADDR_WIDTH, 12, address bits shifted per transaction
- DATA_WIDTH, 8, data bits per transfer
- TIMEOUT, 64, max consecutive cycles without a read bit before abort (≥1)

- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- dvalid  in  1  device request valid
- dready  out  1  high only in IDLE; request accepted on edge with dvalid&&dready
- dmode  in  1  1=write, 0=read, sampled at accept
- daddr  in  ADDR_WIDTH  target address, sampled at accept
- dwdata  in  DATA_WIDTH  write data, sampled at accept
- drdata  out  DATA_WIDTH  last successfully read word, held until next successful read
- ddone  out  1  one-cycle pulse, transaction finished
- derr  out  1  qualifies ddone: 1 = read timed out
- mwdata  out  1  serial address/write data to slave (slave swdata)
- mmode  out  1  transaction mode to slave (slave smode)
- mvalid  out  1  high while master shifts bits (slave mvalid)
- mrdata  in  1  serial read data from slave (slave srdata)
- svalid  in  1  slave read-data bit valid
- sready  in  1  slave idle, may start transaction

## Operation
- States: IDLE, WAIT, ADDR, WDATA, RWAIT, RDATA, DONE.
- IDLE: dready=1. On accept, latch mode/addr/data into shift registers and go to WAIT.
- WAIT: hold until sready=1. At that edge, load mwdata=addr[0], mvalid=1, mmode=latched mode, go to ADDR. There is no timeout in WAIT.
- ADDR: shift one address bit per cycle, ADDR_WIDTH cycles total, LSB first. After the last bit:
  - write: go to WDATA with mwdata=data[0].
  - read: mvalid=0, go to RWAIT.
- WDATA: DATA_WIDTH bits, LSB first, mvalid stays high. After the last bit, mvalid=0 and go to DONE.
- RWAIT/RDATA: each edge with svalid=1 shifts mrdata in, LSB first, into bit position = count.
  - Gaps in svalid are tolerated; only svalid=1 cycles count.
  - A wait counter increments on svalid=0 cycles and clears on each captured bit.
  - When the counter reaches TIMEOUT: go to DONE with derr=1; drdata is unchanged.
  - When DATA_WIDTH bits are captured: drdata loads the assembled word, go to DONE, derr=0.
- DONE: ddone=1 for exactly one cycle, then IDLE.
- mmode holds its value for the whole transaction and returns to 0 in IDLE. mwdata=0 whenever mvalid=0.
- Bit counter width is $clog2(max(ADDR_WIDTH,DATA_WIDTH)). Timeout counter width is $clog2(TIMEOUT+1).
- svalid/mrdata are ignored outside RWAIT/RDATA. sready is ignored outside WAIT.

## Timing
- Reset values: mvalid=0, mwdata=0, mmode=0, ddone=0, derr=0, drdata=0, state IDLE (dready=1).
- Reset mid-transaction: all outputs go to reset values immediately. The transaction is dropped and no ddone is produced.
- Write, accept at edge 0, sready=1:
  - mvalid high from edge 1 to edge 1+ADDR_WIDTH+DATA_WIDTH.
  - ddone high for the cycle after that edge.
  - With defaults: mvalid edges 1..21, ddone set at edge 21.
- Read, same start:
  - mvalid high for ADDR_WIDTH cycles (edges 1..13 with defaults).
  - ddone and drdata are set at the edge after the edge sampling the final svalid bit.
- Each cycle sready stays low in WAIT delays everything by one cycle.
- A new request can be accepted on the edge after ddone clears (IDLE). Back-to-back throughput is therefore one transaction per latency+2 cycles.

## Test plan
- Write: daddr=12'h4D5, dwdata=8'hD5, sready=1.
  - mvalid high 20 cycles, mmode=1.
  - mwdata sequence 1,0,1,0,1,0,1,1,0,0,1,0 then 1,0,1,0,1,0,1,1.
  - ddone=1, derr=0.
- Read: daddr=12'h4D5; slave returns 8'hD5 on svalid with 3-cycle gap after address.
  - mvalid high 12 cycles, mmode=0.
  - drdata=8'hD5, ddone pulse, derr=0.
- Read, svalid deasserted for 2 cycles mid-word after bit 3 -> drdata still 8'hD5, no error.
- Read, svalid never asserted -> ddone with derr=1 exactly TIMEOUT=64 cycles after mvalid falls; drdata keeps previous value.
- sready held low 5 cycles after accept -> mvalid first rises at edge 6; dready stays 0 throughout.
- rstn pulsed low during WDATA bit 3 -> mvalid/mwdata/mmode 0 immediately, no ddone, dready=1. A following write then completes normally.
